clk_ratio_monitor: RTL and testbench

CLK_RATIO_MONITOR -- requirements
Module: clk_ratio_monitor

---
 rtl/clk_ratio_monitor.sv | 152 +++++++++++++++
 tb/tb_clk_ratio_monitor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_ratio_monitor.sv
// clk_ratio_monitor
//   Measures the period and high time of a slow, asynchronous divided-clock
//   signal in units of the system clock. It optionally compares the period
//   against an expected divider value and flags a missing edge.
//
// Ports
//   clk        system clock; all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   en         measurement enable; low returns the monitor to IDLE
//   sig_in     signal under test, asynchronous to clk
//   exp_div    expected period in clk cycles (0 disables the match check)
//   period     last measured period in clk cycles
//   high_time  last measured high duration in clk cycles
//   meas_valid one-cycle pulse when period/high_time/match update
//   match      period equalled exp_div (nonzero) at the last result
//   timeout    sticky flag: no rising edge within 2^CNT_W-1 cycles
module clk_ratio_monitor #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] exp_div,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             match,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             match_q, match_d;
  logic             timeout_q, timeout_d;

  logic             rise;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hcnt_inc;

  // Synchronizer (s1, s2) plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // Saturating increments: counters stick at all-ones and never wrap.
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign hcnt_inc = (s2_q && (hcnt_q != CNT_MAX)) ? hcnt_q + CNT_ONE : hcnt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    match_d   = match_q;
    timeout_d = timeout_q;

    if (!en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      hcnt_d    = '0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d   = '0;
          hcnt_d  = '0;
        end
        ARM, MEASURE: begin
          if (rise) begin
            // A rise wins over saturation in the same cycle; the first
            // rise after arming only starts a measurement.
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
            state_d = MEASURE;
            if (state_q == MEASURE) begin
              period_d  = cnt_q;
              high_d    = hcnt_q;
              match_d   = (cnt_q == exp_div) && (exp_div != '0);
              valid_d   = 1'b1;
              timeout_d = 1'b0;
            end
          end else begin
            cnt_d  = cnt_inc;
            hcnt_d = hcnt_inc;
            if (cnt_q == CNT_MAX) begin
              timeout_d = 1'b1;
              state_d   = ARM;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      match_q   <= match_d;
      timeout_q <= timeout_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = valid_q;
  assign match      = match_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Testbench for clk_ratio_monitor: waveform stimulus (directed corner cases
// plus randomized dividers/duty cycles) checked every cycle against a
// reference model that works from the sampled sig_in history and edge indices.
module tb_clk_ratio_monitor;

  localparam int unsigned W   = 8;
  localparam int          MAX = 255;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         sig_in = 1'b0;
  logic [W-1:0] exp_div = '0;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         meas_valid;
  logic         match;
  logic         timeout;

  clk_ratio_monitor #(.CNT_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sig_in    (sig_in),
    .exp_div   (exp_div),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .match     (match),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[k] is sig_in as sampled at edge k. A rise is acted on at edge e when
  // the samples taken at edges e-3, e-2 are 0, 1. Samples before the last
  // reset release read as 0. m_ref is the edge from which the running count
  // is measured; the count seen at edge e is min(e - m_ref, MAX).
  bit hist [0:199999];
  int e       = 0;
  int rst_idx = 0;
  int m_mode  = 0;   // 0 idle, 1 armed, 2 measuring
  int m_ref   = 0;
  int m_period = 0;
  int m_high   = 0;
  bit m_match  = 0;
  bit m_valid  = 0;
  bit m_to     = 0;

  function automatic int v(input int k);
    if (k < 0 || k < rst_idx) return 0;
    return int'(hist[k]);
  endfunction

  always @(posedge clk) begin
    int c;
    int h;
    bit r;
    hist[e] = sig_in;
    if (!rst_n) begin
      m_mode = 0; m_ref = 0; m_period = 0; m_high = 0;
      m_match = 0; m_valid = 0; m_to = 0;
      rst_idx = e + 1;
    end else begin
      r = (v(e - 2) == 1) && (v(e - 3) == 0);
      m_valid = 0;
      if (!en) begin
        m_mode = 0;
        m_to   = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
        m_ref  = e + 1;
      end else begin
        c = e - m_ref;
        if (c > MAX) c = MAX;
        if (r) begin
          if (m_mode == 2) begin
            h = 0;
            for (int x = m_ref; x < e; x++) h += v(x - 2);
            m_period = c;
            m_high   = (h > MAX) ? MAX : h;
            m_match  = (c == int'(exp_div)) && (exp_div != 0);
            m_valid  = 1;
            m_to     = 0;
          end
          m_mode = 2;
          m_ref  = e;
        end else if (c == MAX) begin
          m_to   = 1;
          m_mode = 1;
        end
      end
    end
    e++;
    #1;
    check_eq("meas_valid", 32'(meas_valid), 32'(m_valid));
    check_eq("period",     32'(period),     32'(m_period));
    check_eq("high_time",  32'(high_time),  32'(m_high));
    check_eq("match",      32'(match),      32'(m_match));
    check_eq("timeout",    32'(timeout),    32'(m_to));
  end

  // ---------------- stimulus ----------------
  task automatic wave(input int n, input int h, input int p);
    for (int i = 0; i < p; i++)
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        sig_in = (c < h);
      end
  endtask

  task automatic hold(input logic val, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      sig_in = val;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int h;
    int p;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    // div-by-2, exact match
    exp_div = 8'd2;
    wave(2, 1, 12);
    // 1-of-3 duty, match
    exp_div = 8'd3;
    wave(3, 1, 8);
    // div-by-4 50% against exp 3: mismatch
    wave(4, 2, 8);

    // one rise then held low: timeout at saturation, then recovery
    hold(1'b1, 1);
    hold(1'b0, 300);
    wave(4, 2, 4);

    // held high: no result and a timeout
    hold(1'b1, 300);
    wave(5, 2, 4);

    // period at and just beyond the saturation boundary
    exp_div = 8'd255;
    wave(255, 1, 3);
    wave(256, 1, 3);
    exp_div = 8'd4;
    wave(4, 2, 4);

    // reset asserted mid-period: outputs clear at once
    wave(4, 2, 2);
    @(negedge clk);
    sig_in = 1'b1;
    rst_n  = 1'b0;
    #1;
    check_eq("rst_period",  32'(period),     32'd0);
    check_eq("rst_high",    32'(high_time),  32'd0);
    check_eq("rst_valid",   32'(meas_valid), 32'd0);
    check_eq("rst_match",   32'(match),      32'd0);
    check_eq("rst_timeout", 32'(timeout),    32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wave(4, 2, 6);

    // en dropped for one cycle in a div-by-2 stream
    exp_div = 8'd2;
    wave(2, 1, 5);
    @(negedge clk);
    en = 1'b0;
    sig_in = ~sig_in;
    @(negedge clk);
    en = 1'b1;
    sig_in = ~sig_in;
    wave(2, 1, 6);

    // exp_div = 0 disables match
    exp_div = 8'd0;
    wave(3, 2, 4);

    // randomized dividers, duties and expected values
    for (int t = 0; t < 40; t++) begin
      n = int'($urandom_range(2, 12));
      h = int'($urandom_range(1, n - 1));
      p = int'($urandom_range(2, 6));
      case ($urandom_range(0, 3))
        0, 1: exp_div = W'(n);
        2:    exp_div = '0;
        default: exp_div = W'($urandom_range(1, 15));
      endcase
      for (int i = 0; i < p; i++)
        for (int c = 0; c < n; c++) begin
          @(negedge clk);
          sig_in = (c < h);
          if ($urandom_range(0, 29) == 0) exp_div = W'($urandom_range(0, 12));
        end
    end

    hold(1'b0, 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
